// File: rtl/food_placer.sv
// Food placement for the snake game: filters random candidates against the body, falls back to a linear scan, detects eating.
// Optional FOOD_SCORE_EN adds a saturating 8-bit score counter output.
module food_placer #(
  parameter int COORD_W   = 3,
  parameter int MAX_TRIES = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [COORD_W-1:0]            cand_x,
  input  logic [COORD_W-1:0]            cand_y,
  input  logic [COORD_W-1:0]            head_x,
  input  logic [COORD_W-1:0]            head_y,
  input  logic                          step,
  input  logic [(1<<(2*COORD_W))-1:0]   occupancy,
  output logic [COORD_W-1:0]            food_x,
  output logic [COORD_W-1:0]            food_y,
  output logic                          food_valid,
  output logic                          eaten,
  output logic                          place_fail
`ifdef FOOD_SCORE_EN
  ,
  output logic [7:0]                    score
`endif
);
  localparam int IDX_W = 2*COORD_W;

  typedef enum logic [1:0] {SEEK, SCAN, HOLD, FULL} state_t;

  state_t             state, state_n;
  logic [7:0]         tries, tries_n, tries_inc;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [COORD_W-1:0] food_x_n, food_y_n;
  logic               food_valid_n, eaten_n, place_fail_n;
  logic [IDX_W-1:0]   cand_idx;
  logic               cand_free, scan_free, hit;

  assign cand_idx  = {cand_y, cand_x};
  assign cand_free = ~occupancy[cand_idx];
  assign scan_free = ~occupancy[idx];
  assign hit       = step && (head_x == food_x) && (head_y == food_y);
  assign tries_inc = tries + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SEEK;
      tries      <= '0;
      idx        <= '0;
      food_x     <= '0;
      food_y     <= '0;
      food_valid <= 1'b0;
      eaten      <= 1'b0;
      place_fail <= 1'b0;
    end else begin
      state      <= state_n;
      tries      <= tries_n;
      idx        <= idx_n;
      food_x     <= food_x_n;
      food_y     <= food_y_n;
      food_valid <= food_valid_n;
      eaten      <= eaten_n;
      place_fail <= place_fail_n;
    end
  end

  always_comb begin
    state_n      = state;
    tries_n      = tries;
    idx_n        = idx;
    food_x_n     = food_x;
    food_y_n     = food_y;
    food_valid_n = food_valid;
    eaten_n      = 1'b0;
    place_fail_n = place_fail;
    case (state)
      SEEK: begin
        if (cand_free) begin
          food_x_n     = cand_x;
          food_y_n     = cand_y;
          food_valid_n = 1'b1;
          state_n      = HOLD;
        end else begin
          tries_n = tries_inc;
          if (tries_inc == 8'(MAX_TRIES)) begin
            idx_n   = '0;
            state_n = SCAN;
          end
        end
      end
      SCAN: begin
        if (scan_free) begin
          food_x_n     = idx[COORD_W-1:0];
          food_y_n     = idx[IDX_W-1:COORD_W];
          food_valid_n = 1'b1;
          state_n      = HOLD;
        end else if (idx == '1) begin
          place_fail_n = 1'b1;
          state_n      = FULL;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      HOLD: begin
        // Eat pulse and valid clear land on the same edge; search restarts next cycle.
        if (hit) begin
          eaten_n      = 1'b1;
          food_valid_n = 1'b0;
          tries_n      = '0;
          state_n      = SEEK;
        end
      end
      default: ;
    endcase
  end

`ifdef FOOD_SCORE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          score <= '0;
    else if (eaten_n && score != 8'hFF) score <= score + 8'd1;
  end
`endif

endmodule

// File: tb/tb_food_placer.sv
// Bench for food_placer: directed scenarios then randomized traffic against a cycle-level behavioural model.
module tb_food_placer;
  localparam int CW    = 3;
  localparam int N     = 8;
  localparam int CELLS = 64;
  localparam int MT    = 8;

  logic              clk = 0;
  logic              reset = 1;
  logic [CW-1:0]     cand_x = 0, cand_y = 0, head_x = 0, head_y = 0;
  logic              step = 0;
  logic [CELLS-1:0]  occupancy = '0;
  logic [CW-1:0]     food_x, food_y;
  logic              food_valid, eaten, place_fail;
`ifdef FOOD_SCORE_EN
  logic [7:0]        score;
`endif

  food_placer #(.COORD_W(CW), .MAX_TRIES(MT)) dut (
    .clk(clk), .reset(reset), .cand_x(cand_x), .cand_y(cand_y),
    .head_x(head_x), .head_y(head_y), .step(step), .occupancy(occupancy),
    .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
    .eaten(eaten), .place_fail(place_fail)
`ifdef FOOD_SCORE_EN
    , .score(score)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: 0 searching randomly, 1 scanning, 2 food placed, 3 board full
  int m_mode, m_tries, m_idx, m_fx, m_fy, m_score;
  bit m_fv, m_eat, m_fail;

  task automatic model_reset();
    m_mode = 0; m_tries = 0; m_idx = 0; m_fx = 0; m_fy = 0;
    m_fv = 0; m_eat = 0; m_fail = 0; m_score = 0;
  endtask

  task automatic model_step();
    int ci;
    ci = int'(cand_y) * N + int'(cand_x);
    m_eat = 0;
    if (m_mode == 0) begin
      if (occupancy[ci] == 1'b0) begin
        m_fx = cand_x; m_fy = cand_y; m_fv = 1; m_mode = 2;
      end else begin
        m_tries++;
        if (m_tries == MT) begin m_mode = 1; m_idx = 0; end
      end
    end else if (m_mode == 1) begin
      if (occupancy[m_idx] == 1'b0) begin
        m_fx = m_idx % N; m_fy = m_idx / N; m_fv = 1; m_mode = 2;
      end else if (m_idx == CELLS - 1) begin
        m_fail = 1; m_mode = 3;
      end else m_idx++;
    end else if (m_mode == 2) begin
      if (step && int'(head_x) == m_fx && int'(head_y) == m_fy) begin
        m_eat = 1; m_fv = 0; m_tries = 0; m_mode = 0;
        if (m_score < 255) m_score++;
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".food_x"}, int'(food_x), m_fx);
    chk({tag, ".food_y"}, int'(food_y), m_fy);
    chk({tag, ".food_valid"}, int'(food_valid), int'(m_fv));
    chk({tag, ".eaten"}, int'(eaten), int'(m_eat));
    chk({tag, ".place_fail"}, int'(place_fail), int'(m_fail));
`ifdef FOOD_SCORE_EN
    chk({tag, ".score"}, int'(score), m_score);
`endif
  endtask

  task automatic cyc(input string tag);
    model_step();
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1; #1;
    model_reset();
    check_all(tag);
    @(posedge clk); #1;
    reset = 0;
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    check_all("reset");
    reset = 0;

    // First-try accept, then eat and re-place
    occupancy = '0; cand_x = 3; cand_y = 1;
    cyc("accept31");
    chk("accept31.fv_const", int'(food_valid), 1);
    head_x = 3; head_y = 1; step = 1; cand_x = 2; cand_y = 5;
    cyc("eat31");
    chk("eat31.eaten_const", int'(eaten), 1);
    step = 0;
    cyc("accept25");
    chk("accept25.x_const", int'(food_x), 2);
    chk("accept25.eaten_clear", int'(eaten), 0);
    head_x = 0; head_y = 0; step = 1;
    cyc("step_miss");

    // Random tries exhausted, scan finds index 0
    do_reset("rst2");
    occupancy = '0; occupancy[11] = 1; occupancy[33] = 1;
    for (int i = 0; i < MT; i++) begin
      if (i % 2 == 0) begin cand_x = 3; cand_y = 1; end
      else begin cand_x = 1; cand_y = 4; end
      cyc("tries");
    end
    cyc("scan0");
    chk("scan0.fv_const", int'(food_valid), 1);

    // Only the last cell free
    do_reset("rst3");
    occupancy = '1; occupancy[63] = 0; cand_x = 2; cand_y = 2;
    for (int i = 0; i < MT + CELLS; i++) cyc("scan63");
    chk("scan63.x_const", int'(food_x), 7);
    chk("scan63.y_const", int'(food_y), 7);

    // Full board is sticky until reset
    do_reset("rst4");
    occupancy = '1;
    for (int i = 0; i < MT + CELLS + 5; i++) cyc("full");
    chk("full.fail_const", int'(place_fail), 1);
    do_reset("full_rst");
    chk("full_rst.fail_const", int'(place_fail), 0);
    occupancy = '0; cand_x = 4; cand_y = 6;
    cyc("after_full");

`ifdef FOOD_SCORE_EN
    cand_x = 0; cand_y = 0; head_x = 0; head_y = 0;
    for (int i = 0; i < 260; i++) begin
      step = 0; cyc("sc_place");
      step = 1; cyc("sc_eat");
    end
    step = 0;
    chk("score_sat", int'(score), 255);
    occupancy = '1;
    cyc("sc_search"); cyc("sc_search");
    do_reset("sc_rst");
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 3))
          0: occupancy = '0;
          1: occupancy = {$urandom, $urandom};
          2: occupancy = {$urandom | $urandom, $urandom | $urandom};
          default: begin
            occupancy = '1;
            if ($urandom_range(0, 1) == 1) occupancy[$urandom_range(0, CELLS-1)] = 1'b0;
          end
        endcase
      end
      cand_x = CW'($urandom); cand_y = CW'($urandom);
      step = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 1) begin head_x = CW'(m_fx); head_y = CW'(m_fy); end
      else begin head_x = CW'($urandom); head_y = CW'($urandom); end
      if ($urandom_range(0, 299) == 0 || (m_fail && $urandom_range(0, 9) == 0))
        do_reset("rnd_rst");
      else
        cyc("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
